// File: rtl/fetch_ibuf_pkg.sv
// rtl/fetch_ibuf_pkg.sv - shared core constants and fetch-entry layout
package fetch_ibuf_pkg;

  localparam int CORE_XLEN = 32;
  localparam int CORE_ILEN = 32;
  localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = 32'h0000_0000;

  // One buffered fetch: the PC travels with its instruction word, PC in the upper bits.
  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ibuf_if.sv
// rtl/fetch_ibuf_if.sv - instruction-memory and decode-side bundle of the fetch stage
interface fetch_ibuf_if import fetch_ibuf_pkg::*; #(
  parameter int XLEN    = CORE_XLEN,
  parameter int IMEM_AW = 8,
  parameter int DEPTH   = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  // Suffixes are relative to the fetch stage.
  logic                 imem_req_o;
  logic [IMEM_AW-1:0]   imem_addr_o;
  logic [CORE_ILEN-1:0] imem_inst_i;
  logic                 deq_valid_o;
  logic                 deq_ready_i;
  logic [XLEN-1:0]      deq_pc_o;
  logic [CORE_ILEN-1:0] deq_inst_o;
  logic [CW-1:0]        count_o;

  modport master (
    output imem_req_o, imem_addr_o, deq_valid_o, deq_pc_o, deq_inst_o, count_o,
    input  imem_inst_i, deq_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, deq_valid_o, deq_pc_o, deq_inst_o, count_o,
    output imem_inst_i, deq_ready_i
  );

endinterface

// File: rtl/fetch_ibuf_sync_fifo.sv
// rtl/fetch_ibuf_sync_fifo.sv - power-of-two synchronous FIFO with flush and occupancy count
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok, push_ok;

  // Pointer/count update; a simultaneous push and pop leaves count unchanged, flush drops everything.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    mem_d   = mem_q;
    pop_ok  = pop_i & (count_q != '0);
    push_ok = push_i & ((count_q != CW'(DEPTH)) | pop_ok);
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (pop_ok) begin
        rd_d = rd_q + AW'(1);
      end
      if (push_ok) begin
        mem_d[wr_q] = push_data_i;
        wr_d        = wr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible through count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_data_o = mem_q[rd_q];
  assign valid_o     = (count_q != '0);
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_ibuf.sv
// rtl/fetch_ibuf.sv - PC generation, credit-based fetch issue and decoupling instruction buffer
module fetch_ibuf import fetch_ibuf_pkg::*; #(
  parameter int              XLEN     = CORE_XLEN,
  parameter int              IMEM_AW  = 8,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(CORE_RESET_PC)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  fetch_ibuf_if.master    bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = XLEN + CORE_ILEN;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;

  logic [CW-1:0]   count;
  logic            head_valid;
  logic [EW-1:0]   head_data;
  logic            deq_fire;
  logic            req;
  logic            push, pop;
  logic [CW:0]     committed;

  // Issue only when every buffered, in-flight and about-to-leave entry still leaves a free slot.
  always_comb begin
    deq_fire  = head_valid & bus.deq_ready_i;
    committed = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(deq_fire);
    req       = ~reset_i & ~redirect_i & (committed < (CW+1)'(DEPTH));
    push      = inflight_q & ~kill_q & ~redirect_i;
    pop       = deq_fire & ~redirect_i;
  end

  // Next PC / in-flight tracking; a redirect overrides any request and poisons a pending return.
  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    kill_d        = 1'b0;
    if (redirect_i) begin
      pc_d   = redirect_pc_i & ~XLEN'(3);
      kill_d = inflight_q;
    end else if (req) begin
      inflight_pc_d = pc_q;
      inflight_d    = 1'b1;
      pc_d          = pc_q + XLEN'(4);
    end
  end

  // Fetch-control registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      kill_q        <= kill_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i ({inflight_pc_q, bus.imem_inst_i}),
    .pop_i       (pop),
    .head_data_o (head_data),
    .valid_o     (head_valid),
    .count_o     (count)
  );

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc_q[IMEM_AW+1:2];
  assign bus.deq_valid_o = head_valid;
  assign bus.deq_pc_o    = head_data[EW-1:CORE_ILEN];
  assign bus.deq_inst_o  = head_data[CORE_ILEN-1:0];
  assign bus.count_o     = count;

endmodule

// File: tb/tb_fetch_ibuf.sv
// tb/tb_fetch_ibuf.sv - randomized and directed self-checking bench for fetch_ibuf
module tb_fetch_ibuf;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk;
  logic        reset_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  fetch_ibuf_if #(.XLEN(32), .IMEM_AW(8), .DEPTH(DEPTH)) bus ();

  fetch_ibuf #(.XLEN(32), .IMEM_AW(8), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  ent_t        m_q[$];
  logic [31:0] m_pc = RST_PC;
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_pc = '0;
  logic [31:0] next_inst = '0;

  function automatic logic [31:0] mem_of(input logic [7:0] w);
    return 32'hC0DE_0000 ^ ({24'h0, w} * 32'h0000_9E37);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, compare DUT against the queue model, then advance the model.
  task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic fire;
    logic exp_req;
    int   occ;
    @(negedge clk);
    reset_i         = r;
    redirect_i      = rd;
    redirect_pc_i   = rpc;
    bus.deq_ready_i = rdy;
    bus.imem_inst_i = next_inst;
    #1;
    fire    = (m_q.size() > 0) && rdy;
    occ     = m_q.size() + (m_pend ? 1 : 0) - (fire ? 1 : 0);
    exp_req = !r && !rd && (occ < DEPTH);
    if (r) begin
      chk("req_in_reset", bus.imem_req_o, 0);
    end else begin
      chk("imem_req", bus.imem_req_o, exp_req);
      chk("imem_addr", bus.imem_addr_o, m_pc[9:2]);
      chk("count", bus.count_o, m_q.size());
      chk("deq_valid", bus.deq_valid_o, m_q.size() > 0);
      if (m_q.size() > 0) begin
        chk("deq_pc", bus.deq_pc_o, m_q[0].pc);
        chk("deq_inst", bus.deq_inst_o, m_q[0].inst);
      end
    end
    next_inst = $urandom;
    if (r) begin
      m_q.delete();
      m_pc   = RST_PC;
      m_pend = 1'b0;
    end else if (rd) begin
      m_q.delete();
      m_pc   = rpc & ~32'd3;
      m_pend = 1'b0;
    end else begin
      if (fire) void'(m_q.pop_front());
      if (m_pend) m_q.push_back('{pc: m_pend_pc, inst: mem_of(m_pend_pc[9:2])});
      if (exp_req) begin
        next_inst = mem_of(m_pc[9:2]);
        m_pend_pc = m_pc;
        m_pend    = 1'b1;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int bias;
    logic r, rd, rdy;
    logic [31:0] rpc;
    reset_i         = 1'b1;
    redirect_i      = 1'b0;
    redirect_pc_i   = '0;
    bus.deq_ready_i = 1'b0;
    bus.imem_inst_i = '0;

    // Streaming after reset: first dequeue two cycles after release.
    do_reset();
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_first_req", bus.imem_req_o, 1);
    chk("lit_first_addr", bus.imem_addr_o, 0);
    chk("lit_reset_count", bus.count_o, 0);
    chk("lit_reset_valid", bus.deq_valid_o, 0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_c1_valid", bus.deq_valid_o, 0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_c2_pc", bus.deq_pc_o, 32'h0);
    chk("lit_c2_inst", bus.deq_inst_o, 32'hC0DE_0000);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_c3_pc", bus.deq_pc_o, 32'h4);
    chk("lit_c3_inst", bus.deq_inst_o, 32'hC0DE_9E37);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Back-pressure from reset: fills to DEPTH, stops requesting with pc at 16.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("lit_full_count", bus.count_o, 4);
    chk("lit_full_req", bus.imem_req_o, 0);
    chk("lit_full_addr", bus.imem_addr_o, 4);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_drain_pc", bus.deq_pc_o, 32'h0);
    chk("lit_drain_req", bus.imem_req_o, 1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Redirect with three buffered entries and one in flight.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    chk("lit_redir_count_before", bus.count_o, 3);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_redir_count_after", bus.count_o, 0);
    chk("lit_redir_addr", bus.imem_addr_o, 8'h10);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_redir_t2_valid", bus.deq_valid_o, 0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_redir_t3_pc", bus.deq_pc_o, 32'h40);

    // Misaligned redirect target is word-aligned.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 32'h43, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_mis_addr", bus.imem_addr_o, 8'h10);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_mis_pc", bus.deq_pc_o, 32'h40);

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_wrap_addr0", bus.imem_addr_o, 8'hFF);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_wrap_addr1", bus.imem_addr_o, 8'h00);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_wrap_pc0", bus.deq_pc_o, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_wrap_pc1", bus.deq_pc_o, 32'h0);

    // Reset with a full buffer and a fetch in flight.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_rst_count", bus.count_o, 0);
    chk("lit_rst_valid", bus.deq_valid_o, 0);
    chk("lit_rst_addr", bus.imem_addr_o, 0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lit_rst_pc", bus.deq_pc_o, 32'h0);

    // Randomized traffic with varying back-pressure, redirects and resets.
    bias = 100;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: bias = 10;
          1: bias = 50;
          2: bias = 90;
          default: bias = 100;
        endcase
      end
      r   = ($urandom_range(0, 299) == 0);
      rd  = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 99) < bias);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      cycle(r, rd, rpc, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ibuf.md
# fetch_ibuf

Parametrised fetch stage with a decoupling instruction buffer. It generates the PC, issues one request per cycle to a synchronous instruction memory with 1-cycle read latency, and captures each returned word with its PC in a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready handshake. Branch redirects flush the buffer and cancel the in-flight fetch, and back-pressure stalls the PC through credit counting rather than a blunt stall input.

## Interface
Parameters:
- XLEN, 32, PC and instruction width.
- IMEM_AW, 8, instruction-memory word-address width (PC bits [IMEM_AW+1:2]).
- DEPTH, 4, buffer entries; power of two, ≥2.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- redirect_i  in  1  flush buffer and load redirect_pc_i.
- redirect_pc_i  in  XLEN  new PC; bits [1:0] ignored (treated as 0).
- imem_req_o  out  1  request issued this cycle.
- imem_addr_o  out  IMEM_AW  word address = pc[IMEM_AW+1:2].
- imem_inst_i  in  32  read data, valid the cycle after a request.
- deq_valid_o  out  1  buffer head holds a valid instruction.
- deq_ready_i  in  1  decode accepts head this cycle.
- deq_pc_o  out  XLEN  PC of head entry.
- deq_inst_o  out  32  instruction of head entry.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- State: pc, inflight bit, inflight_pc, kill bit, FIFO (rd/wr pointers, count).
- deq_fire = deq_valid_o & deq_ready_i; pops the head.
- Credit: imem_req_o = !reset_i & !redirect_i & (count + inflight − deq_fire < DEPTH). It is combinational from deq_ready_i.
- On a request: inflight_pc ← pc, inflight ← 1, pc ← pc + 4. The increment wraps modulo 2^XLEN, and imem_addr_o truncates silently.
- No request: pc holds, inflight ← 0.
- Return cycle, inflight=1 and kill=0: push {inflight_pc, imem_inst_i}. Push and pop in the same cycle are both honoured, so count is unchanged.
- Redirect (priority over everything):
  - count ← 0 and pointers reset.
  - pc ← {redirect_pc_i[XLEN-1:2], 2'b00}.
  - kill ← inflight, so a return arriving next cycle is discarded.
  - inflight ← 0.
  - No request is issued in the redirect cycle, and a deq_fire in that cycle is still reported to decode but has no effect on state.
- kill clears the cycle after it is set.
- Reset mid-operation has the same effect as redirect to RESET_PC, plus inflight and kill are cleared.

## Timing
- Reset values: pc=RESET_PC, count_o=0, deq_valid_o=0, imem_req_o=0 during reset, inflight=0, kill=0. deq_pc_o/deq_inst_o are don't-care while invalid.
- First request is issued in the first cycle after reset deasserts.
- Latency:
  - Request at t → imem_inst_i at t+1 → entry written at the end of t+1 → deq_valid_o at t+2.
  - Redirect at t → request at t+1 for the new PC → deq_valid_o at t+3.
- Throughput: 1 instruction/cycle sustained when deq_ready_i=1 (DEPTH ≥2).
- Full: count + inflight = DEPTH with no pop → imem_req_o=0 and pc holds. Overflow is impossible by construction.
- Empty: deq_valid_o=0; deq_ready_i is ignored.
- Outputs deq_* and count_o are register-driven; only imem_req_o/imem_addr_o depend combinationally on inputs (imem_addr_o from pc only).

## Structure
- Shared core package/header: XLEN, RESET_PC, instruction width constant, and the fetch-entry field layout {pc, inst}.
- Sub-module: sync_fifo (WIDTH=XLEN+32, DEPTH), with push/pop/flush and count output, reusable by later queues.
- fetch_ibuf contains PC/credit/kill logic only, about 150–250 lines including the FIFO.

## Test plan
- Reset then deq_ready_i=1 for 10 cycles → deq_pc_o sequence 0,4,8,… starting cycle 2 after reset release, one per cycle, instructions match memory.
- deq_ready_i=0 from reset (DEPTH=4) → exactly 4 entries buffered, count_o=4, imem_req_o=0 thereafter, pc=16. Release ready → PCs 0..12 drain, then 16 onward with no gap or duplicate.
- Redirect to 0x40 while the buffer holds 3 entries and a request is in flight → count_o=0 next cycle, in-flight word discarded, first dequeued PC=0x40 at redirect+3.
- redirect_pc_i=0x43 → fetch address word 0x10, deq_pc_o=0x40.
- PC at 0xFFFF_FFFC → next PC 0x0, imem_addr_o wraps to 0.
- Assert reset_i with a full buffer and a request in flight → next cycle count_o=0, deq_valid_o=0; after release, fetch restarts at RESET_PC.
